// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one bit pair per clock, LSB first, through a single full-adder cell.
// Optional subtract mode when SERIAL_SUB_EN is defined (adds the sub port).

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_0,
  output logic S,
  output logic c
);
  assign S = a ^ b ^ c_0;
  assign c = (a & b) | (c_0 & (a ^ b));
endmodule

// state  | meaning
// IDLE   | waiting for start; sum/cout hold the last result
// RUN    | one bit added per edge, WIDTH edges total
// DONE   | result valid, done pulse; returns to IDLE unconditionally
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    count_q;
  logic             carry_q, cout_q, busy_q, done_q;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] sum_d, b_load;
  logic             carry_load, last_bit;

  full_adder_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .c_0 (carry_q),
    .S   (fa_s),
    .c   (fa_c)
  );

  // Subtraction is a + ~b + 1, so only the loaded operand and carry change.
  always_comb begin
    b_load     = b;
    carry_load = cin;
`ifdef SERIAL_SUB_EN
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end
`endif
  end

  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_d = fa_s;
    end else begin : g_sum_wn
      assign sum_d = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= carry_load;
            count_q <= '0;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_c;
          sum_q   <= sum_d;
          count_q <= count_q + CW'(1);
          if (last_bit) begin
            cout_q  <= fa_c;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed testbench for bit_serial_adder (WIDTH=8); subtract cases run when SERIAL_SUB_EN is defined.

module tb_bit_serial_adder;
  localparam int WIDTH = 8;
  localparam int MAXC  = 40;

  logic             clk = 1'b0;
  logic             rst, start, cin, sub;
  logic [WIDTH-1:0] a, b, sum;
  logic             cout, busy, done;

  int errors = 0;
  int checks = 0;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation and waits (bounded) for done; reports busy cycles and edges to done.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input logic sv,
                        output int busy_cnt, output int lat);
    start = 1'b1; a = av; b = bv; cin = cv; sub = sv;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    lat = 0;
    while (!done && lat < MAXC) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, want all zero", busy, done, cout, sum);
    end
  endtask

  task automatic test_add();
    logic [WIDTH-1:0] va [4] = '{8'h35, 8'hFF, 8'h80, 8'hFF};
    logic [WIDTH-1:0] vb [4] = '{8'h4A, 8'h01, 8'h80, 8'hFF};
    logic             vc [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
    logic [WIDTH-1:0] es [4] = '{8'h7F, 8'h00, 8'h01, 8'hFF};
    logic             ec [4] = '{1'b0,  1'b1,  1'b1,  1'b1};
    int bc, lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, bc, lat);
      checks++;
      if (bc !== WIDTH || lat !== WIDTH) begin
        errors++;
        $display("FAIL add_latency[%0d]: busy_cycles=%0d edges_to_done=%0d, want %0d/%0d", i, bc, lat, WIDTH, WIDTH);
      end
      checks++;
      if ({cout, sum} !== {ec[i], es[i]}) begin
        errors++;
        $display("FAIL add_result[%0d]: cout=%b sum=%h, want cout=%b sum=%h", i, cout, sum, ec[i], es[i]);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== {ec[i], es[i]}) begin
        errors++;
        $display("FAIL add_after_done[%0d]: done=%b busy=%b cout=%b sum=%h, want done=0 busy=0 result held", i, done, busy, cout, sum);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int dcount = 0;
    logic [WIDTH-1:0] s_at_done = '0;
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'hAA;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        dcount++;
        s_at_done = sum;
      end
      tick();
    end
    checks++;
    if (dcount !== 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d pulses, want 1", dcount);
    end
    checks++;
    if (s_at_done !== 8'h10) begin
      errors++;
      $display("FAIL restart_sum: got %h, want 10", s_at_done);
    end
  endtask

  task automatic test_abort();
    int dcount = 0;
    int bc, lat;
    start = 1'b1; a = 8'h35; b = 8'h4A; cin = 1'b0; sub = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b cout=%b sum=%h, want all zero", busy, done, cout, sum);
    end
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    checks++;
    if (dcount !== 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d busy/done cycles after abort, want 0", dcount);
    end
    run_op(8'hC3, 8'h5A, 1'b0, 1'b0, bc, lat);
    checks++;
    if (lat !== WIDTH || {cout, sum} !== {1'b1, 8'h1D}) begin
      errors++;
      $display("FAIL abort_rerun: edges=%0d cout=%b sum=%h, want 8 cout=1 sum=1d", lat, cout, sum);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
    tick();
    a = 8'hF0; b = 8'h20;
    n = 0;
    while (!done && n < MAXC) begin tick(); n++; end
    checks++;
    if (n !== WIDTH || {cout, sum} !== {1'b0, 8'h46}) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d cout=%b sum=%h, want 8 cout=0 sum=46", n, cout, sum);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b, want 0/0", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b at edge k+10, want 1", busy);
    end
    start = 1'b0;
    n = 0;
    while (!done && n < MAXC) begin tick(); n++; end
    checks++;
    if (n !== WIDTH || {cout, sum} !== {1'b1, 8'h10}) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d cout=%b sum=%h, want 8 cout=1 sum=10", n, cout, sum);
    end
    tick();
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    int bc, lat;
    run_op(8'h10, 8'h01, 1'b0, 1'b1, bc, lat);
    checks++;
    if (lat !== WIDTH || {cout, sum} !== {1'b1, 8'h0F}) begin
      errors++;
      $display("FAIL sub_no_borrow: edges=%0d cout=%b sum=%h, want 8 cout=1 sum=0f", lat, cout, sum);
    end
    tick();
    run_op(8'h01, 8'h02, 1'b0, 1'b1, bc, lat);
    checks++;
    if (lat !== WIDTH || {cout, sum} !== {1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL sub_borrow: edges=%0d cout=%b sum=%h, want 8 cout=0 sum=ff", lat, cout, sum);
    end
    tick();
    run_op(8'h20, 8'h05, 1'b1, 1'b0, bc, lat);
    checks++;
    if ({cout, sum} !== {1'b0, 8'h26}) begin
      errors++;
      $display("FAIL sub_off_add: cout=%b sum=%h, want cout=0 sum=26", cout, sum);
    end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_add();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
